hub75_multi_scan: RTL and testbench

- Parametrised HUB75 scan engine: drives NUM_PANELS chained or parallel panels from one timing core.
- Shared row address, LAT, OE and CLK lines; per-panel RGB outputs.
- Fetches bit-planes from an external framebuffer read port (1-cycle latency).
- Shifts the next plane while the current plane is displayed, using binary-code modulation with a runtime brightness setting.
- Sits between the UDP-fed framebuffer and the panel pins, replacing per-panel duplicated scan logic.

---
 rtl/hub75_multi_scan.sv | 159 +++++++++++++++
 tb/tb_hub75_multi_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hub75_multi_scan.sv
// HUB75 scan engine: one timing core, shared row/LAT/OE/CLK, per-panel RGB, BCM display.
// Optional macro HUB75_DEGHOST_EN adds 4 blank cycles before and after a row-address change.
module hub75_multi_scan #(
  parameter int NUM_PANELS = 6,
  parameter int COLS       = 64,
  parameter int SCAN_ROWS  = 32,
  parameter int BITS       = 8,
  parameter int CLK_DIV    = 1,
  parameter int BRIGHT_W   = 8
) (
  input  logic                                     clock,
  input  logic                                     resetn,
  input  logic                                     enable,
  input  logic [BRIGHT_W-1:0]                      brightness,
  output logic                                     rd_en,
  output logic [$clog2(SCAN_ROWS)-1:0]             rd_row,
  output logic [$clog2(COLS)-1:0]                  rd_col,
  output logic [((BITS > 1) ? $clog2(BITS) : 1)-1:0] rd_plane,
  input  logic [6*NUM_PANELS-1:0]                  rd_bits,
  output logic [6*NUM_PANELS-1:0]                  panel_rgb,
  output logic [4:0]                               panel_addr,
  output logic                                     panel_clk,
  output logic                                     panel_lat,
  output logic                                     panel_oe,
  output logic                                     frame_start,
  output logic                                     busy,
  output logic [2:0]                               dbg_state
);
  localparam int AW  = $clog2(SCAN_ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int PW  = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int DW  = BRIGHT_W + BITS;
  localparam int PHW = $clog2(2 * CLK_DIV + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_BLANK = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [PHW-1:0] PH_LAST    = PHW'(2 * CLK_DIV);
  localparam logic [PHW-1:0] PH_CAP     = PHW'(1);
  localparam logic [PHW-1:0] PH_HIGH    = PHW'(CLK_DIV);
  localparam logic [CW-1:0]  COL_LAST   = CW'(COLS - 1);
  localparam logic [AW-1:0]  ROW_LAST   = AW'(SCAN_ROWS - 1);
  localparam logic [PW-1:0]  PLANE_LAST = PW'(BITS - 1);

  logic [2:0]     state;
  logic [AW-1:0]  row, addr_r;
  logic [CW-1:0]  col;
  logic [PW-1:0]  plane;
  logic [PHW-1:0] ph;
  logic [DW-1:0]  dcnt, load_val;
  logic [2:0]     ghost_cnt;
  logic           pre_done, disp_ending, last_slot;

  assign load_val  = DW'(brightness) << plane;
  assign last_slot = (row == ROW_LAST) && (plane == PLANE_LAST);
  // High when the display window (including any post-latch blanking) is in its last cycle.
  assign disp_ending = (ghost_cnt == 3'd0) ? (dcnt <= DW'(1))
                                           : ((ghost_cnt == 3'd1) && (dcnt == '0));

`ifdef HUB75_DEGHOST_EN
  logic       row_change;
  logic [2:0] pre_cnt;

  assign row_change = (row != addr_r);
  assign pre_done   = !row_change || (pre_cnt == 3'd4);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pre_cnt   <= 3'd0;
      ghost_cnt <= 3'd0;
    end else begin
      if (state == S_BLANK && !pre_done) pre_cnt <= pre_cnt + 3'd1;
      else                               pre_cnt <= 3'd0;
      if (state == S_LATCH)              ghost_cnt <= row_change ? 3'd4 : 3'd0;
      else if (ghost_cnt != 3'd0)        ghost_cnt <= ghost_cnt - 3'd1;
    end
  end
`else
  assign ghost_cnt = 3'd0;
  assign pre_done  = 1'b1;
`endif

  // Read port: rd_en with address in column cycle 0, rd_bits valid exactly one cycle later.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      plane       <= '0;
      ph          <= '0;
      dcnt        <= '0;
      addr_r      <= '0;
      panel_rgb   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (dcnt != '0 && ghost_cnt == 3'd0) dcnt <= dcnt - DW'(1);
      if (state == S_SHIFT && ph == PH_CAP) panel_rgb <= rd_bits;
      case (state)
        S_IDLE: begin
          if (enable) begin
            state       <= S_SHIFT;
            frame_start <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            if (col == COL_LAST) begin
              col   <= '0;
              state <= disp_ending ? S_BLANK : S_WAIT;
            end else begin
              col <= col + CW'(1);
            end
          end else begin
            ph <= ph + PHW'(1);
          end
        end
        S_WAIT:  if (disp_ending) state <= S_BLANK;
        S_BLANK: if (pre_done) state <= S_LATCH;
        S_LATCH: begin
          addr_r <= row;
          dcnt   <= load_val;
          if (plane == PLANE_LAST) begin
            plane <= '0;
            row   <= row + AW'(1);
          end else begin
            plane <= plane + PW'(1);
          end
          if (!last_slot) begin
            state <= S_SHIFT;
          end else if (enable) begin
            state       <= S_SHIFT;
            frame_start <= 1'b1;
          end else begin
            state <= (load_val == '0) ? S_IDLE : S_DRAIN;
          end
        end
        S_DRAIN: if (disp_ending) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_en      = (state == S_SHIFT) && (ph == '0);
  assign rd_row     = row;
  assign rd_col     = col;
  assign rd_plane   = plane;
  assign panel_clk  = (state == S_SHIFT) && (ph > PH_HIGH);
  assign panel_lat  = (state == S_LATCH);
  assign panel_oe   = (dcnt == '0) || (ghost_cnt != 3'd0);
  assign panel_addr = 5'(addr_r);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;
endmodule

// File: tb/tb_hub75_multi_scan.sv
// Bench for hub75_multi_scan: randomized framebuffer/brightness checked against a timeline model.
module tb_hub75_multi_scan;
  localparam int NP      = 2;
  localparam int COLS    = 4;
  localparam int SR      = 2;
  localparam int BITS    = 2;
  localparam int CLK_DIV = 1;
  localparam int BW      = 8;
  localparam int RGBW    = 6 * NP;
  localparam int COLP    = 1 + 2 * CLK_DIV;
  localparam int MAXC    = 4096;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            enable = 1'b0;
  logic [BW-1:0]   brightness = '0;
  logic            rd_en;
  logic [0:0]      rd_row;
  logic [1:0]      rd_col;
  logic [0:0]      rd_plane;
  logic [RGBW-1:0] rd_bits = '0;
  logic [RGBW-1:0] panel_rgb;
  logic [4:0]      panel_addr;
  logic            panel_clk, panel_lat, panel_oe, frame_start, busy;
  logic [2:0]      dbg_state;

  hub75_multi_scan #(
    .NUM_PANELS(NP), .COLS(COLS), .SCAN_ROWS(SR), .BITS(BITS),
    .CLK_DIV(CLK_DIV), .BRIGHT_W(BW)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .brightness(brightness),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_plane(rd_plane),
    .rd_bits(rd_bits), .panel_rgb(panel_rgb), .panel_addr(panel_addr),
    .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe(panel_oe),
    .frame_start(frame_start), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Framebuffer with one cycle read latency.
  logic [RGBW-1:0] fb [SR][COLS][BITS];
  always @(posedge clock) if (rd_en) rd_bits <= fb[rd_row][rd_col][rd_plane];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Expected per-cycle timeline, index 0 = first SHIFT cycle of the run.
  bit e_oe_low [MAXC];
  bit e_lat    [MAXC];
  bit e_rden   [MAXC];
  bit e_clk    [MAXC];
  bit e_fs     [MAXC];
  bit e_busy   [MAXC];
  int e_row    [MAXC];
  int e_col    [MAXC];
  int e_plane  [MAXC];
  int e_addr   [MAXC];
  int slot_start [$];
  int slot_lat   [$];
  int run_len;
  logic [RGBW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slot k: shift takes COLS*COLP cycles, one blank cycle once both the shift and the
  // previous display are over, then the latch; display lasts brightness<<plane cycles.
  function automatic void build(input int b, input int nframes, input int addr0);
    int s, z, lat, d, bk, idle_at;
    for (int t = 0; t < MAXC; t++) begin
      e_oe_low[t] = 0; e_lat[t] = 0; e_rden[t] = 0; e_clk[t] = 0; e_fs[t] = 0;
      e_busy[t] = 0; e_row[t] = 0; e_col[t] = 0; e_plane[t] = 0; e_addr[t] = addr0;
    end
    exp_q.delete();
    slot_start.delete();
    slot_lat.delete();
    s = 0;
    z = -1;
    for (int f = 0; f < nframes; f++)
      for (int r = 0; r < SR; r++)
        for (int p = 0; p < BITS; p++) begin
          slot_start.push_back(s);
          if (r == 0 && p == 0) e_fs[s] = 1;
          for (int c = 0; c < COLS; c++) begin
            int t0;
            t0 = s + c * COLP;
            e_rden[t0] = 1; e_row[t0] = r; e_col[t0] = c; e_plane[t0] = p;
            for (int k = CLK_DIV + 1; k <= 2 * CLK_DIV; k++) e_clk[t0 + k] = 1;
            exp_q.push_back(fb[r][c][p]);
          end
          bk = (s + COLS * COLP > z) ? s + COLS * COLP : z;
          lat = bk + 1;
          slot_lat.push_back(lat);
          e_lat[lat] = 1;
          d = b << p;
          for (int t = lat + 1; t <= lat + d; t++) e_oe_low[t] = 1;
          for (int t = lat + 1; t < MAXC; t++) e_addr[t] = r;
          z = lat + d + 1;
          s = lat + 1;
        end
    idle_at = z;
    for (int t = 0; t < idle_at; t++) e_busy[t] = 1;
    run_len = idle_at + 6;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_oe"}, panel_oe, 1);
    check({tag, "_lat"}, panel_lat, 0);
    check({tag, "_clk"}, panel_clk, 0);
    check({tag, "_rden"}, rd_en, 0);
    check({tag, "_rgb"}, panel_rgb, 0);
    check({tag, "_addr"}, panel_addr, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_row"}, rd_row, 0);
    check({tag, "_col"}, rd_col, 0);
    check({tag, "_plane"}, rd_plane, 0);
  endtask

  task automatic run_frames(input int b, input int nframes, input int addr0, input int abort_at);
    int drop_idx, n_lat, n_fs;
    bit prev_clk;
    brightness = BW'(b);
    build(b, nframes, addr0);
    drop_idx = slot_start[SR * BITS * (nframes - 1)] + int'($urandom_range(0, 10));
    n_lat = 0;
    n_fs = 0;
    prev_clk = 0;
    enable = 1'b1;
    @(negedge clock);
    for (int i = 0; i < run_len; i++) begin
      check("oe", panel_oe, !e_oe_low[i]);
      check("lat", panel_lat, e_lat[i]);
      check("rd_en", rd_en, e_rden[i]);
      if (e_rden[i]) begin
        check("rd_row", rd_row, e_row[i]);
        check("rd_col", rd_col, e_col[i]);
        check("rd_plane", rd_plane, e_plane[i]);
      end
      check("pclk", panel_clk, e_clk[i]);
      check("fstart", frame_start, e_fs[i]);
      check("busy", busy, e_busy[i]);
      check("addr", panel_addr, e_addr[i]);
      if (panel_lat) n_lat++;
      if (frame_start) n_fs++;
      if (panel_clk && !prev_clk) begin
        if (exp_q.size() == 0) check("rgb_extra", 1, 0);
        else check("rgb", panel_rgb, exp_q.pop_front());
      end
      prev_clk = panel_clk;
      if (i == drop_idx) enable = 1'b0;
      if (i == abort_at) begin
        enable = 1'b0;
        return;
      end
      @(negedge clock);
    end
    check("rgb_left", exp_q.size(), 0);
    check("lat_count", n_lat, SR * BITS * nframes);
    check("fs_count", n_fs, nframes);
  endtask

  task automatic fill_fb(input bit constant, input logic [RGBW-1:0] value);
    for (int r = 0; r < SR; r++)
      for (int c = 0; c < COLS; c++)
        for (int p = 0; p < BITS; p++)
          fb[r][c][p] = constant ? value : RGBW'($urandom);
  endtask

  initial begin
    // Reset held for three clock edges.
    resetn = 1'b0;
    enable = 1'b0;
    fill_fb(1'b1, 12'hA5C);
    repeat (3) @(negedge clock);
    check_idle("rst");
    check("state_rst", dbg_state, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Shift timing and BCM weighting with constant read data.
    run_frames(3, 1, 0, -1);
    check("end_busy", busy, 0);
    check("end_oe", panel_oe, 1);

    // Long display overlapping the next shift.
    fill_fb(1'b0, '0);
    run_frames(200, 1, 1, -1);

    // Randomized brightness, data and frame count, including the extremes.
    for (int k = 0; k < 6; k++) begin
      int b;
      b = (k == 0) ? 0 : (k == 1) ? 255 : int'($urandom_range(1, 254));
      fill_fb(1'b0, '0);
      run_frames(b, int'($urandom_range(1, 2)), 1, -1);
    end

    // Reset while the first plane is on display, then a clean restart.
    fill_fb(1'b0, '0);
    run_frames(50, 1, 1, 15);
    check("pre_rst_oe", panel_oe, 0);
    resetn = 1'b0;
    @(negedge clock);
    check_idle("midrst");
    resetn = 1'b1;
    @(negedge clock);
    run_frames(50, 1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
